// File: rtl/imem_loader.sv
// Boot-time program loader: assembles big-endian words from a byte stream,
// writes them to instruction memory, and holds the core in reset until done.
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH:0]   load_len,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [31:0]           imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_RUN
  } state_e;

  localparam logic [ADDR_WIDTH:0]   MAX_LEN = (ADDR_WIDTH + 1)'(MAX_WORDS);
  localparam logic [ADDR_WIDTH:0]   LEN_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE = ADDR_WIDTH'(1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH:0]     len_q, len_d;
  logic [ADDR_WIDTH-1:0]   word_idx_q, word_idx_d;
  logic [1:0]              byte_idx_q, byte_idx_d;
  logic [31:0]             shift_q, shift_d;
  logic                    error_q, error_d;

  logic len_ok;
  logic last_word;
  logic byte_hs;

  assign len_ok    = (load_len != '0) && (load_len <= MAX_LEN);
  assign last_word = ({1'b0, word_idx_q} == (len_q - LEN_ONE));
  assign byte_hs   = byte_valid && (state_q == S_RECV);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    error_d    = error_q;

    unique case (state_q)
      S_IDLE, S_RUN: begin
        if (load_start) begin
          if (len_ok) begin
            len_d      = load_len;
            word_idx_d = '0;
            byte_idx_d = '0;
            error_d    = 1'b0;
            state_d    = S_RECV;
          end else begin
            // A rejected load from RUN drops back to IDLE, re-asserting cpu_reset.
            error_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_RECV: begin
        if (byte_hs) begin
          shift_d    = {shift_q[23:0], byte_data};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (last_word) begin
          state_d = S_RUN;
        end else begin
          word_idx_d = word_idx_q + IDX_ONE;
          state_d    = S_RECV;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Every output is a decode of registered state; nothing combinational from inputs.
  assign byte_ready = (state_q == S_RECV);
  assign imem_we    = (state_q == S_WRITE);
  assign imem_addr  = {{(30 - ADDR_WIDTH){1'b0}}, word_idx_q, 2'b00};
  assign imem_wdata = shift_q;
  assign cpu_reset  = (state_q != S_RUN);
  assign done       = (state_q == S_RUN);
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed/random bench for imem_loader: a word-level reference model predicts
// every memory write, its cycle, and the cycle the core leaves reset.
module tb_imem_loader;

  localparam int AW = 8;
  localparam int MW = 256;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          load_start = 1'b0;
  logic [AW:0]   load_len = '0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = '0;
  logic          byte_ready;
  logic          imem_we;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          done;
  logic          error;

  imem_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MW)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_start (load_start),
    .load_len   (load_len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  // Observed write log and reset-release cycle, captured mid-cycle.
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          fall_cyc = -1;
  logic        prev_cr  = 1'b1;

  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (prev_cr === 1'b1 && cpu_reset === 1'b0 && fall_cyc < 0) fall_cyc = cyc;
    prev_cr = cpu_reset;
  end

  // Reference model: expected word contents and the cycle each write must occur in.
  logic [31:0] exp_word_q[$];
  int          exp_cyc_q[$];
  logic [7:0]  fixed_b[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    exp_word_q.delete();
    exp_cyc_q.delete();
    fall_cyc = -1;
  endtask

  task automatic pulse_start(input int len);
    load_start = 1'b1;
    load_len   = (AW + 1)'(len);
    tick();
    load_start = 1'b0;
  endtask

  // Present one byte, optionally after idle cycles; returns once it is consumed.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
    int n;
    byte_valid = 1'b0;
    repeat (gap) tick();
    byte_valid = 1'b1;
    byte_data  = b;
    if (poke) begin
      load_start = 1'b1;
      load_len   = (AW + 1)'(5);
    end
    n = 0;
    while (byte_ready !== 1'b1 && n < 20) begin
      tick();
      load_start = 1'b0;
      n++;
    end
    chk("hs_wait", 32'(n < 20), 32'd1);
    tick();
    byte_valid = 1'b0;
    load_start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("done_wait", 32'(n < 50), 32'd1);
    repeat (2) tick();
  endtask

  task automatic check_writes(input string tag, input int len);
    chk({tag, "_nwr"}, 32'(wr_addr_q.size()), 32'(len));
    for (int i = 0; i < len && i < wr_addr_q.size(); i++) begin
      chk({tag, "_addr"}, wr_addr_q[i], 32'(i * 4));
      chk({tag, "_data"}, wr_data_q[i], exp_word_q[i]);
      chk({tag, "_wcyc"}, 32'(wr_cyc_q[i]), 32'(exp_cyc_q[i]));
    end
  endtask

  task automatic do_load(input int len, input int maxgap, input bit fixed, input bit poke);
    logic [31:0] w;
    logic [7:0]  b;
    clear_log();
    pulse_start(len);
    for (int wi = 0; wi < len; wi++) begin
      w = '0;
      for (int k = 0; k < 4; k++) begin
        b = fixed ? fixed_b[k] : 8'($urandom);
        w = {w[23:0], b};
        send_byte(b, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0, poke && wi == 0 && k == 1);
      end
      exp_word_q.push_back(w);
      exp_cyc_q.push_back(cyc);
    end
    wait_done();
    check_writes("load", len);
    if (len > 0) chk("release_cyc", 32'(fall_cyc), 32'(exp_cyc_q[len-1] + 1));
    chk("run_done", 32'(done), 32'd1);
    chk("run_cpu_reset", 32'(cpu_reset), 32'd0);
  endtask

  initial begin
    logic [31:0] w0;
    logic [7:0]  b;
    int          nwr;

    // Reset state, held and after release.
    #1;
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_byte_ready", 32'(byte_ready), 32'd0);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();
    chk("idle_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("idle_byte_ready", 32'(byte_ready), 32'd0);

    // Single fixed word back-to-back.
    fixed_b[0] = 8'h20; fixed_b[1] = 8'h08; fixed_b[2] = 8'h00; fixed_b[3] = 8'h05;
    do_load(1, 0, 1'b1, 1'b0);
    chk("fixed_word", (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hdead_beef, 32'h2008_0005);
    $display("load len=1 fixed: %0d write(s), release at cycle %0d", wr_addr_q.size(), fall_cyc);

    // Three words with random byte gaps.
    do_load(3, 3, 1'b0, 1'b0);
    $display("load len=3 gapped: %0d write(s), release at cycle %0d", wr_addr_q.size(), fall_cyc);

    // Bad lengths: 0 and MAX+1 (issued from RUN, then from IDLE).
    clear_log();
    pulse_start(0);
    tick();
    chk("len0_error", 32'(error), 32'd1);
    chk("len0_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("len0_byte_ready", 32'(byte_ready), 32'd0);
    pulse_start(MW + 1);
    tick();
    chk("lenmax1_error", 32'(error), 32'd1);
    chk("lenmax1_byte_ready", 32'(byte_ready), 32'd0);
    chk("badlen_nwr", 32'(wr_addr_q.size()), 32'd0);
    $display("bad lengths 0 and %0d: error=%0b", MW + 1, error);
    do_load(2, 1, 1'b0, 1'b0);
    chk("recover_error", 32'(error), 32'd0);
    $display("load len=2 after error: %0d write(s)", wr_addr_q.size());

    // Reset after 6 bytes of a 2-word load.
    clear_log();
    pulse_start(2);
    w0 = '0;
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      if (k < 4) w0 = {w0[23:0], b};
      send_byte(b, 0, 1'b0);
    end
    reset = 1'b1;
    #1;
    chk("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("midrst_byte_ready", 32'(byte_ready), 32'd0);
    chk("midrst_imem_we", 32'(imem_we), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("midrst_nwr", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() > 0) begin
      chk("midrst_addr", wr_addr_q[0], 32'h0);
      chk("midrst_data", wr_data_q[0], w0);
    end
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    repeat (4) tick();
    byte_valid = 1'b0;
    chk("idle_bytes_nwr", 32'(wr_addr_q.size()), 32'd1);
    chk("idle_after_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    $display("reset mid-load: %0d write(s) kept", wr_addr_q.size());

    // Reach RUN, then reload from RUN with a stray load_start during RECV.
    do_load(1, 0, 1'b0, 1'b0);
    load_start = 1'b1;
    load_len   = (AW + 1)'(1);
    tick();
    load_start = 1'b0;
    chk("reload_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("reload_done", 32'(done), 32'd0);
    chk("reload_byte_ready", 32'(byte_ready), 32'd1);
    clear_log();
    w0 = '0;
    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom);
      w0 = {w0[23:0], b};
      send_byte(b, int'($urandom_range(0, 2)), k == 1);
    end
    exp_word_q.push_back(w0);
    exp_cyc_q.push_back(cyc);
    wait_done();
    check_writes("reload", 1);
    chk("reload_release", 32'(fall_cyc), 32'(exp_cyc_q[0] + 1));
    nwr = wr_addr_q.size();
    byte_valid = 1'b1;
    repeat (3) tick();
    byte_valid = 1'b0;
    chk("run_bytes_nwr", 32'(wr_addr_q.size()), 32'(nwr));
    chk("run_byte_ready", 32'(byte_ready), 32'd0);
    $display("reload from RUN: %0d write(s), done=%0b", nwr, done);

    // Full capacity load.
    do_load(MW, 0, 1'b0, 1'b0);
    chk("full_last_addr", (wr_addr_q.size() > 0) ? wr_addr_q[wr_addr_q.size()-1] : 32'hffff_ffff,
        32'h0000_03FC);
    $display("load len=%0d: %0d write(s), release at cycle %0d", MW, wr_addr_q.size(), fall_cyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
